// File: rtl/data_memory_arbiter_pkg.sv
// Shared encodings for the data memory arbiter: FSM states and requester ids.
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; the pointer names the port favoured on a tie
// and moves to the non-winner whenever the owner reports a completed access.
module data_memory_arbiter_rr_arbiter2
    import data_memory_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       winner_i,
    output logic       valid_o,
    output logic       grant_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        valid_o = |req_i;
        grant_o = PORT0;
        case (req_i)
            2'b01:   grant_o = PORT0;
            2'b10:   grant_o = PORT1;
            2'b11:   grant_o = ptr_q;
            default: grant_o = PORT0;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = ~winner_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between two req/ack requesters:
// grant in IDLE, one registered memory cycle in ACCESS, ack pulse in RESP.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    arb_state_e            state_q, state_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  grant_valid;
    logic                  grant_id;
    logic                  ptr_update;

    data_memory_arbiter_rr_arbiter2 u_rr_arbiter2 (
        .clk_i    (clk),
        .rst_ni   (reset),
        .req_i    ({m1_req, m0_req}),
        .update_i (ptr_update),
        .winner_i (win_q),
        .valid_o  (grant_valid),
        .grant_o  (grant_id)
    );

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        ptr_update = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ACCESS;
                    win_d   = grant_id;
                    if (grant_id == PORT1) begin
                        we_d    = m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                    end else begin
                        we_d    = m0_we;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                    end
                end
            end
            ACCESS: begin
                // Strobes come from state_q so reset kills a pending write at once.
                mem_write  = we_q;
                mem_read   = ~we_q;
                ptr_update = 1'b1;
                state_d    = RESP;
                if (!we_q) begin
                    if (win_q == PORT1) begin
                        m1_rdata_d = mem_read_data;
                    end else begin
                        m0_rdata_d = mem_read_data;
                    end
                end
            end
            RESP: begin
                m0_ack  = (win_q == PORT0);
                m1_ack  = (win_q == PORT1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            win_q      <= PORT0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Latched request registers only change on a grant, so they also provide the hold.
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign m0_rdata       = m0_rdata_q;
    assign m1_rdata       = m1_rdata_q;

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (core load/store stage) and port 1 (auxiliary master, e.g. debug/loader).
- Round-robin arbitration, req/ack handshake per port.
- Registered, one-cycle memory access per grant; drives the memory's write data, address, write enable and read enable.
- Returns the read word to the winning port.

Parameters:
- DATA_WIDTH, 32, width of data words and of each port's read/write data.
- ADDR_WIDTH, 32, width of byte addresses; forwarded unmodified (the memory performs its own word/base translation).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req  input  1  port 0 request; held high until m0_ack.
- m0_we  input  1  port 0 write (1) / read (0); stable while m0_req high.
- m0_addr  input  ADDR_WIDTH  port 0 byte address.
- m0_wdata  input  DATA_WIDTH  port 0 write data.
- m0_ack  output  1  one-cycle completion pulse for port 0.
- m0_rdata  output  DATA_WIDTH  port 0 read data, valid while m0_ack high.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same directions, widths and meanings for port 1.
- mem_write  output  1  memory write enable.
- mem_read  output  1  memory read enable.
- mem_address  output  ADDR_WIDTH  memory address.
- mem_write_data  output  DATA_WIDTH  memory write data.
- mem_read_data  input  DATA_WIDTH  memory combinational read data (already gated by mem_read).

Behaviour:
- Reset (async, reset low), all asserted immediately:
  - State IDLE; round-robin pointer favours port 0.
  - mem_write = 0, mem_read = 0, mem_address = 0, mem_write_data = 0.
  - m0_ack = 0, m1_ack = 0, m0_rdata = 0, m1_rdata = 0.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant it.
  - Both high: grant the port the pointer favours.
  - On grant: latch winner id, we, addr, wdata into internal registers; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_address and mem_write_data are driven from the latched registers.
  - mem_write = latched we; mem_read = NOT latched we.
  - At the closing edge: memory commits the write; for a read, mem_read_data is registered into the winner's rdata.
  - Pointer flips to favour the non-winner; go to RESP.
- RESP (exactly 1 cycle):
  - Winner's ack = 1; mem_write = mem_read = 0; go to IDLE.
- Outside ACCESS: mem_write and mem_read are 0; mem_address and mem_write_data hold their last value.
- Latency: req seen in IDLE at edge N → ack high in cycle N+2. Peak throughput is one access per 3 cycles.
- Handshake rules:
  - Requester drops req at the edge where it samples ack = 1.
  - req is sampled only in IDLE; changes during ACCESS/RESP are ignored.
  - A req still high in IDLE after its ack is treated as a new request.
- Write ack: rdata of the winner is unchanged (holds previous read value).
- The non-winning port's rdata and ack are untouched throughout.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1…; neither port waits more than one foreign access.
- Reset mid-operation (ACCESS or RESP): transaction aborted, no ack issued; mem_write drops asynchronously so no partial write is committed after reset assertion; pointer returns to port 0.
- Addresses and data pass through bit-exact: no alignment check, no width conversion.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Port id constants: PORT0 = 1'b0, PORT1 = 1'b1.
- One natural sub-module: rr_arbiter2 (combinational two-input round-robin grant from req pair and pointer, plus pointer register update).
- FSM and datapath latches live in the top.

Test Plan:
- Reset then idle: reset low 3 cycles, release, no req for 10 cycles → all outputs 0, mem_write/mem_read never asserted.
- Port 0 write then read:
  - m0_req, we = 1, addr 0x1001_0004, wdata 0xDEADBEEF → mem_write = 1 exactly one cycle with those values; m0_ack two cycles after grant.
  - Read back same addr → m0_rdata = 0xDEADBEEF with m0_ack.
- Simultaneous requests: both req high from reset (port 0 reads 0x1001_0000, port 1 writes 0x1234 to 0x1001_0008) → port 0 served first, port 1 second; acks 3 cycles apart.
- Fairness: both ports hold req continuously for 6 transactions → grant order 0,1,0,1,0,1; m1_rdata unchanged during port-0 acks and vice versa.
- Reset mid-operation: assert reset during ACCESS of a port-1 write to 0x1001_000C → mem_write falls immediately, no m1_ack; later read of 0x1001_000C returns the old value.
- Write-ack rdata hold: port 0 reads 0x5555 then writes 0xAAAA → m0_rdata stays 0x5555 during the write's ack.
